// File: rtl/mult_nxn_iter_if.sv
// Request/response bundle for the iterative N x N multiplier.
// The controller drives the operands and start, and the multiplier returns busy, done and product.
interface mult_nxn_iter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mult_nxn_iter.sv
// Iterative sign-selectable WIDTH x WIDTH multiplier built on one CHUNK x CHUNK partial product.
// Leading all-zero chunks of either magnitude are skipped, so narrow operands finish sooner.
module mult_nxn_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic            clk,
  input logic            reset,
  mult_nxn_iter_if.slave bus
);
  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = $clog2(NCH + 1);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned PPW = 2 * CHUNK;
  localparam int unsigned SW  = $clog2(PW);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] ma, ma_d, mb, mb_d;
  logic             neg, neg_d;
  logic [CW-1:0]    na, na_d, nb, nb_d;
  logic [CW-1:0]    ci, ci_d, cj, cj_d;
  logic [PW-1:0]    acc, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [CHUNK-1:0] ca, cb;
  logic [PPW-1:0]   pp;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] abs_a, abs_b;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? WIDTH'(~v + WIDTH'(1)) : v;
  endfunction

  // Number of chunks up to and including the highest nonzero one, never less than 1.
  function automatic logic [CW-1:0] chunk_count(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = CW'(1);
    for (int unsigned k = 0; k < NCH; k++) begin
      if (v[k*CHUNK +: CHUNK] != '0) n = CW'(k + 1);
    end
    return n;
  endfunction

  always_comb begin
    abs_a = magnitude(bus.a, bus.is_signed);
    abs_b = magnitude(bus.b, bus.is_signed);
    ca    = ma[32'(ci) * CHUNK +: CHUNK];
    cb    = mb[32'(cj) * CHUNK +: CHUNK];
    pp    = PPW'(ca) * PPW'(cb);
    shamt = SW'((32'(ci) + 32'(cj)) * CHUNK);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state;
    ma_d      = ma;
    mb_d      = mb;
    neg_d     = neg;
    na_d      = na;
    nb_d      = nb;
    ci_d      = ci;
    cj_d      = cj;
    acc_d     = acc;
    product_d = product_q;
    done_d    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          ma_d    = abs_a;
          mb_d    = abs_b;
          neg_d   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          na_d    = chunk_count(abs_a);
          nb_d    = chunk_count(abs_b);
          acc_d   = '0;
          ci_d    = '0;
          cj_d    = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc + (PW'(pp) << shamt);
        if (cj == nb - CW'(1)) begin
          cj_d = '0;
          if (ci == na - CW'(1)) state_d = FINISH;
          else                   ci_d    = ci + CW'(1);
        end else begin
          cj_d = cj + CW'(1);
        end
      end
      FINISH: begin
        // Two's-complement negation of zero is zero, so no -0 can appear.
        product_d = neg ? (~acc + PW'(1)) : acc;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ma        <= '0;
      mb        <= '0;
      neg       <= 1'b0;
      na        <= '0;
      nb        <= '0;
      ci        <= '0;
      cj        <= '0;
      acc       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_d;
      ma        <= ma_d;
      mb        <= mb_d;
      neg       <= neg_d;
      na        <= na_d;
      nb        <= nb_d;
      ci        <= ci_d;
      cj        <= cj_d;
      acc       <= acc_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_mult_nxn_iter.sv
// Self-checking bench for mult_nxn_iter at 32/8, 16/4 and 64/16.
// Expected products and latencies are queued at issue and compared when done pulses.
module tb_mult_nxn_iter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mult_nxn_iter_if #(.WIDTH(32)) bus32 ();
  mult_nxn_iter_if #(.WIDTH(16)) bus16 ();
  mult_nxn_iter_if #(.WIDTH(64)) bus64 ();

  mult_nxn_iter #(.WIDTH(32), .CHUNK(8))  dut32 (.clk(clk), .reset(reset), .bus(bus32));
  mult_nxn_iter #(.WIDTH(16), .CHUNK(4))  dut16 (.clk(clk), .reset(reset), .bus(bus16));
  mult_nxn_iter #(.WIDTH(64), .CHUNK(16)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

  typedef struct {
    logic [127:0] prod;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] wmask(input int w);
    return (128'(1) << w) - 128'(1);
  endfunction

  // Golden product: sign- or zero-extend to 128 bits, multiply, keep 2*w bits.
  function automatic logic [127:0] gold(input logic [63:0] a, input logic [63:0] b,
                                        input bit s, input int w);
    logic [127:0] m, ax, bx;
    m  = wmask(w);
    ax = 128'(a) & m;
    bx = 128'(b) & m;
    if (s && a[w-1]) ax = ax | ~m;
    if (s && b[w-1]) bx = bx | ~m;
    return (ax * bx) & wmask(2 * w);
  endfunction

  function automatic int nchunks(input logic [63:0] x, input bit s, input int w, input int c);
    logic [127:0] m, xm;
    int n;
    m  = wmask(w);
    xm = 128'(x) & m;
    if (s && x[w-1]) xm = (~xm + 128'(1)) & m;
    n = 1;
    for (int k = 0; k < w / c; k++)
      if (((xm >> (k * c)) & wmask(c)) != 0) n = k + 1;
    return n;
  endfunction

  function automatic int model_lat(input logic [63:0] a, input logic [63:0] b,
                                   input bit s, input int w, input int c);
    return nchunks(a, s, w, c) * nchunks(b, s, w, c) + 1;
  endfunction

  task automatic push_exp(input logic [63:0] a, input logic [63:0] b, input bit s,
                          input int w, input int c, input string tag);
    exp_t e;
    e.prod = gold(a, b, s, w);
    e.lat  = model_lat(a, b, s, w, c);
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic result(input logic [127:0] prod, input int lat, input int bcnt, input bit tmo);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (!tmo) else begin
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done", e.tag);
    end
    chk({e.tag, "_prod"}, prod, e.prod);
    chk({e.tag, "_lat"}, 128'(lat), 128'(e.lat));
    chk({e.tag, "_busy"}, 128'(bcnt), 128'(e.lat));
  endtask

  task automatic op32(input logic [63:0] a, input logic [63:0] b, input bit s,
                      input string tag, input int poke = -1);
    int cyc, bcnt;
    logic [63:0] p;
    @(negedge clk);
    bus32.a = a[31:0]; bus32.b = b[31:0]; bus32.is_signed = s; bus32.start = 1'b1;
    push_exp(a, b, s, 32, 8, tag);
    @(posedge clk); #1;
    cyc = 0; bcnt = 0;
    while (!bus32.done && cyc < 40) begin
      if (bus32.busy) bcnt++;
      if (cyc == poke) begin
        bus32.start = 1'b1; bus32.a = 32'h1234_5678; bus32.is_signed = ~s;
      end else begin
        bus32.start = 1'b0;
      end
      @(posedge clk); #1; cyc++;
    end
    bus32.start = 1'b0;
    chk({tag, "_busy_at_done"}, 128'(bus32.busy), 128'(0));
    p = bus32.product;
    result(128'(p), cyc, bcnt, !bus32.done);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 128'(bus32.done), 128'(0));
    chk({tag, "_hold"}, 128'(bus32.product), 128'(p));
  endtask

  task automatic op16(input logic [63:0] a, input logic [63:0] b, input bit s, input string tag);
    int cyc, bcnt;
    @(negedge clk);
    bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.is_signed = s; bus16.start = 1'b1;
    push_exp(a, b, s, 16, 4, tag);
    @(posedge clk); #1; bus16.start = 1'b0;
    cyc = 0; bcnt = 0;
    while (!bus16.done && cyc < 40) begin
      if (bus16.busy) bcnt++;
      @(posedge clk); #1; cyc++;
    end
    result(128'(bus16.product), cyc, bcnt, !bus16.done);
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b, input bit s, input string tag);
    int cyc, bcnt;
    @(negedge clk);
    bus64.a = a; bus64.b = b; bus64.is_signed = s; bus64.start = 1'b1;
    push_exp(a, b, s, 64, 16, tag);
    @(posedge clk); #1; bus64.start = 1'b0;
    cyc = 0; bcnt = 0;
    while (!bus64.done && cyc < 40) begin
      if (bus64.busy) bcnt++;
      @(posedge clk); #1; cyc++;
    end
    result(bus64.product, cyc, bcnt, !bus64.done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, last, dcnt;
    exp_t e;
    logic [63:0] ra, rb;

    reset = 1'b1;
    bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.a = '0; bus32.b = '0;
    bus16.start = 1'b0; bus16.is_signed = 1'b0; bus16.a = '0; bus16.b = '0;
    bus64.start = 1'b0; bus64.is_signed = 1'b0; bus64.a = '0; bus64.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(bus32.busy), 128'(0));
    chk("rst_done", 128'(bus32.done), 128'(0));
    chk("rst_prod32", 128'(bus32.product), 128'(0));
    chk("rst_prod16", 128'(bus16.product), 128'(0));
    chk("rst_prod64", 128'(bus64.product), 128'(0));
    @(negedge clk); reset = 1'b0;

    // Directed 32x32 cases, including boundaries of the signed range.
    op32(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, "u_full");
    op32(64'h0000_0100, 64'h0000_0003, 1'b0, "early_na2");
    op32(64'h0000_0000, 64'hDEAD_BEEF, 1'b0, "zero_a");
    op32(64'hFFFF_FFFF, 64'h0000_0005, 1'b1, "s_m1x5");
    op32(64'h8000_0000, 64'h8000_0000, 1'b1, "s_minxmin");
    op32(64'h8000_0000, 64'h8000_0000, 1'b0, "u_minxmin");
    op32(64'h0000_0005, 64'hFFFF_FFFB, 1'b1, "s_5xm5");
    op32(64'hFFFF_FFFB, 64'hFFFF_FFFD, 1'b1, "s_m5xm3");
    op32(64'h0000_0000, 64'h8000_0000, 1'b1, "s_zero_neg");
    op32(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, "busy_poke", 3);

    // Start held high: each op accepted the cycle after the previous done.
    @(negedge clk);
    bus32.a = 32'h0000_0100; bus32.b = 32'h0000_0003; bus32.is_signed = 1'b0; bus32.start = 1'b1;
    repeat (3) push_exp(64'h100, 64'h3, 1'b0, 32, 8, "b2b");
    cyc = 0; n = 0; last = 0;
    while (n < 3 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (bus32.done) begin
        e = sb.pop_front();
        chk("b2b_prod", 128'(bus32.product), e.prod);
        if (n > 0) chk("b2b_interval", 128'(cyc - last), 128'(e.lat + 1));
        last = cyc;
        n++;
      end
    end
    bus32.start = 1'b0;
    chk("b2b_count", 128'(n), 128'(3));
    repeat (2) @(posedge clk);

    // Reset five cycles into a 17-cycle op aborts it with no done pulse.
    @(negedge clk);
    bus32.a = 32'hFFFF_FFFF; bus32.b = 32'hFFFF_FFFF; bus32.is_signed = 1'b0; bus32.start = 1'b1;
    @(posedge clk); #1; bus32.start = 1'b0;
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("midrst_busy", 128'(bus32.busy), 128'(0));
    chk("midrst_done", 128'(bus32.done), 128'(0));
    chk("midrst_prod", 128'(bus32.product), 128'(0));
    dcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus32.done) dcnt++;
    end
    chk("midrst_no_done", 128'(dcnt), 128'(0));
    op32(64'h0000_0007, 64'h0000_0009, 1'b0, "after_rst");

    // Parameter sweep: boundary operands then random narrowed operands.
    op16(64'h8000, 64'h8000, 1'b1, "w16_minxmin");
    op16(64'hFFFF, 64'hFFFF, 1'b0, "w16_full");
    op64(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "w64_minxm1");
    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "w64_full");
    for (int k = 0; k < 8; k++) begin
      ra = 64'($urandom) >> $urandom_range(0, 15);
      rb = 64'($urandom) >> $urandom_range(0, 15);
      op16(ra, rb, 1'($urandom_range(0, 1)), "w16_rand");
      ra = {$urandom, $urandom} >> $urandom_range(0, 63);
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      op64(ra, rb, 1'($urandom_range(0, 1)), "w64_rand");
    end

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
